e1_tx_bd_seq: RTL and testbench

- Autonomous TX buffer-descriptor sequencer between host CSR logic and the TX BD-in/BD-out FIFO pair.
- Host only commits filled multiframe (MF) slots and acknowledges completed ones. The block pushes BDs in ring order, pops completions, checks their order and tracks in-flight depth.
- Flags starvation and sequence errors, and produces a host IRQ. This removes per-MF BD writes over the bus.

---
 rtl/e1_tx_bd_seq.sv | 120 ++++++++++++
 tb/tb_e1_tx_bd_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/e1_tx_bd_seq.sv
// e1_tx_bd_seq: autonomous TX BD ring sequencer (host commit/ack, BD submit, in-order completion check, IRQ); E1_TX_BD_SEQ_IRQ_COAL_EN gates the done IRQ on ctrl_irq_thr
module e1_tx_bd_seq #(
  parameter int MFW = 7,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ctrl_ena,
  input  logic [MFW-1:0] ctrl_start_mf,
  input  logic [1:0]     ctrl_crc_e,
  input  logic [3:0]     ctrl_irq_thr,
  input  logic           host_commit,
  input  logic           host_ack,
  output logic [MFW+1:0] bdi_data,
  output logic           bdi_wren,
  input  logic           bdi_full,
  input  logic [MFW-1:0] bdo_data,
  output logic           bdo_rden,
  input  logic           bdo_empty,
  output logic [1:0]     st_state,
  output logic [3:0]     st_inflight,
  output logic [MFW:0]   st_done_cnt,
  output logic           st_starve,
  output logic           st_seq_err,
  output logic           st_commit_ovf,
  output logic           irq
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, ERR = 2'd3;
  localparam logic [MFW+1:0] RING = (MFW+2)'(1) << MFW;
  logic [1:0] state_q, state_d;
  logic [MFW-1:0] wr_ptr_q, wr_ptr_d, done_ptr_q, done_ptr_d;
  logic [MFW:0] commit_cnt_q, commit_cnt_d, done_cnt_q, done_cnt_d;
  logic [3:0] inflight_q, inflight_d;
  logic [MFW+1:0] bdi_data_q, bdi_data_d;
  logic submitted_q, submitted_d, starve_q, starve_d, seq_err_q, seq_err_d, ovf_q, ovf_d;
  logic bdi_wren_q, bdi_wren_d, bdo_rden_q, bdo_rden_d, irq_q, irq_d;
  logic start, live, sub, pop, ok, bad, acc, done_irq;
`ifdef E1_TX_BD_SEQ_IRQ_COAL_EN
  logic [3:0] thr;
  assign thr = ctrl_irq_thr == 4'd0 ? 4'd1 : ctrl_irq_thr;
  assign done_irq = {4'd0, done_cnt_q} >= {{(MFW+1){1'b0}}, thr};
`else
  logic unused_thr;
  assign unused_thr = ^ctrl_irq_thr;
  assign done_irq = done_cnt_q != '0;
`endif
  always_comb begin
    start = state_q == IDLE && ctrl_ena;
    live = state_q == RUN || state_q == DRAIN;
    sub = state_q == RUN && ctrl_ena && commit_cnt_q != '0 && inflight_q < 4'(MAX_INFLIGHT) && !bdi_full && !bdi_wren_q;
    pop = state_q != IDLE && !bdo_empty && !bdo_rden_q;
    ok = pop && live && bdo_data == done_ptr_q;
    bad = pop && live && bdo_data != done_ptr_q;
    acc = state_q == RUN && host_commit && ({1'b0, commit_cnt_q} + {1'b0, done_cnt_q} + (MFW+2)'(inflight_q) < RING);
    state_d = bad ? ERR :
              state_q == IDLE ? (ctrl_ena ? RUN : IDLE) :
              state_q == RUN ? (ctrl_ena ? RUN : DRAIN) :
              state_q == DRAIN ? (inflight_q == 4'd0 ? IDLE : DRAIN) :
              (ctrl_ena ? ERR : IDLE);
    wr_ptr_d = start ? ctrl_start_mf : wr_ptr_q + MFW'(sub);
    done_ptr_d = start ? ctrl_start_mf : done_ptr_q + MFW'(ok);
    commit_cnt_d = (start || (state_q == RUN && !ctrl_ena)) ? '0 : commit_cnt_q + (MFW+1)'(acc) - (MFW+1)'(sub);
    inflight_d = start ? 4'd0 : inflight_q + 4'(sub) - 4'(ok);
    done_cnt_d = start ? '0 :
                 (ok && host_ack) ? done_cnt_q :
                 ok ? (done_cnt_q == RING[MFW:0] ? done_cnt_q : done_cnt_q + 1'b1) :
                 (host_ack && done_cnt_q != '0) ? done_cnt_q - 1'b1 : done_cnt_q;
    submitted_d = !start && (submitted_q || sub);
    starve_d = !start && (starve_q || (state_q == RUN && inflight_q == 4'd0 && commit_cnt_q == '0 && submitted_q));
    seq_err_d = !start && (seq_err_q || bad);
    ovf_d = !start && (ovf_q || (state_q == RUN && host_commit && !acc));
    bdi_wren_d = sub;
    bdi_data_d = sub ? {ctrl_crc_e, wr_ptr_q} : bdi_data_q;
    bdo_rden_d = pop;
    irq_d = done_irq || starve_q || seq_err_q || ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      done_ptr_q <= '0;
      commit_cnt_q <= '0;
      done_cnt_q <= '0;
      inflight_q <= '0;
      bdi_data_q <= '0;
      submitted_q <= 1'b0;
      starve_q <= 1'b0;
      seq_err_q <= 1'b0;
      ovf_q <= 1'b0;
      bdi_wren_q <= 1'b0;
      bdo_rden_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      done_ptr_q <= done_ptr_d;
      commit_cnt_q <= commit_cnt_d;
      done_cnt_q <= done_cnt_d;
      inflight_q <= inflight_d;
      bdi_data_q <= bdi_data_d;
      submitted_q <= submitted_d;
      starve_q <= starve_d;
      seq_err_q <= seq_err_d;
      ovf_q <= ovf_d;
      bdi_wren_q <= bdi_wren_d;
      bdo_rden_q <= bdo_rden_d;
      irq_q <= irq_d;
    end
  end
  assign bdi_data = bdi_data_q;
  assign bdi_wren = bdi_wren_q;
  assign bdo_rden = bdo_rden_q;
  assign st_state = state_q;
  assign st_inflight = inflight_q;
  assign st_done_cnt = done_cnt_q;
  assign st_starve = starve_q;
  assign st_seq_err = seq_err_q;
  assign st_commit_ovf = ovf_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_e1_tx_bd_seq.sv
// tb_e1_tx_bd_seq: randomized and directed checks of e1_tx_bd_seq against a queue-based reference model
module tb_e1_tx_bd_seq;
  localparam int MFW = 7, MAXI = 4, RING = 128;
  logic clk = 1'b0, rst = 1'b1, ctrl_ena = 1'b0;
  logic [6:0] ctrl_start_mf = '0;
  logic [1:0] ctrl_crc_e = '0;
  logic [3:0] ctrl_irq_thr = '0;
  logic host_commit = 1'b0, host_ack = 1'b0, bdi_full = 1'b0, bdo_empty = 1'b1;
  logic [6:0] bdo_data = '0;
  logic [8:0] bdi_data;
  logic bdi_wren, bdo_rden, st_starve, st_seq_err, st_commit_ovf, irq;
  logic [1:0] st_state;
  logic [3:0] st_inflight;
  logic [7:0] st_done_cnt;
  int n_vec = 0, n_err = 0, cyc_n = 0, last_wr = -10;
  int bdi_q[$], bdo_q[$], wr_log[$];
  bit tx_go = 1'b0, full_rnd = 1'b0;
  int m_st = 0, m_wr = 0, m_pend = 0, m_done = 0;
  int m_q[$];
  bit m_starve = 0, m_err = 0, m_ovf = 0, m_any = 0, m_wren = 0, m_rden = 0, m_irq = 0;
  logic [8:0] m_wdata = '0;

  e1_tx_bd_seq #(.MFW(MFW), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst), .ctrl_ena(ctrl_ena), .ctrl_start_mf(ctrl_start_mf),
    .ctrl_crc_e(ctrl_crc_e), .ctrl_irq_thr(ctrl_irq_thr), .host_commit(host_commit),
    .host_ack(host_ack), .bdi_data(bdi_data), .bdi_wren(bdi_wren), .bdi_full(bdi_full),
    .bdo_data(bdo_data), .bdo_rden(bdo_rden), .bdo_empty(bdo_empty), .st_state(st_state),
    .st_inflight(st_inflight), .st_done_cnt(st_done_cnt), .st_starve(st_starve),
    .st_seq_err(st_seq_err), .st_commit_ovf(st_commit_ovf), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit sub, pop, live, ok, bad, acc, irq_n;
    int expd, infl0;
    if (rst) begin
      m_st = 0; m_wr = 0; m_pend = 0; m_done = 0; m_q.delete();
      m_starve = 0; m_err = 0; m_ovf = 0; m_any = 0; m_wren = 0; m_rden = 0; m_irq = 0; m_wdata = '0;
      return;
    end
    infl0 = m_q.size();
`ifdef E1_TX_BD_SEQ_IRQ_COAL_EN
    irq_n = m_done >= (ctrl_irq_thr == 4'd0 ? 1 : int'(ctrl_irq_thr));
`else
    irq_n = m_done != 0;
`endif
    irq_n = irq_n | m_starve | m_err | m_ovf;
    expd = infl0 > 0 ? m_q[0] : m_wr;
    live = m_st == 1 || m_st == 2;
    sub = m_st == 1 && ctrl_ena && m_pend > 0 && infl0 < MAXI && !bdi_full && !m_wren;
    pop = m_st != 0 && !bdo_empty && !m_rden;
    ok = pop && live && int'(bdo_data) == expd;
    bad = pop && live && !ok;
    acc = m_st == 1 && host_commit && (m_pend + infl0 + m_done < RING);
    if (sub) m_wdata = {ctrl_crc_e, 7'(m_wr)};
    m_wren = sub;
    m_rden = pop;
    m_irq = irq_n;
    if (m_st == 0 && ctrl_ena) begin
      m_st = 1; m_wr = int'(ctrl_start_mf); m_pend = 0; m_done = 0; m_q.delete();
      m_starve = 0; m_err = 0; m_ovf = 0; m_any = 0;
    end else begin
      if (m_st == 1 && infl0 == 0 && m_pend == 0 && m_any) m_starve = 1;
      if (bad) m_err = 1;
      if (m_st == 1 && host_commit && !acc) m_ovf = 1;
      if (ok) void'(m_q.pop_front());
      if (sub) begin m_q.push_back(m_wr); m_wr = (m_wr + 1) % RING; m_any = 1; end
      m_pend = (m_st == 1 && !ctrl_ena) ? 0 : m_pend + int'(acc) - int'(sub);
      if (ok && !host_ack) m_done = m_done < RING ? m_done + 1 : m_done;
      else if (!ok && host_ack && m_done > 0) m_done--;
      m_st = bad ? 3 : m_st == 1 ? (ctrl_ena ? 1 : 2) : m_st == 2 ? (infl0 == 0 ? 0 : 2) :
             m_st == 3 ? (ctrl_ena ? 3 : 0) : 0;
    end
  endtask

  task automatic cyc(input logic cm = 1'b0, input logic ak = 1'b0);
    @(negedge clk);
    cyc_n++;
    model_step();
    chk("state", st_state, m_st);
    chk("inflight", st_inflight, m_q.size());
    chk("done_cnt", st_done_cnt, m_done);
    chk("bdi_wren", bdi_wren, m_wren);
    if (m_wren) chk("bdi_data", bdi_data, m_wdata);
    chk("bdo_rden", bdo_rden, m_rden);
    chk("flags", {st_starve, st_seq_err, st_commit_ovf}, {m_starve, m_err, m_ovf});
    chk("irq", irq, m_irq);
    if (bdi_wren) begin
      chk("wr_gap", 32'(cyc_n - last_wr >= 2), 1);
      last_wr = cyc_n;
      bdi_q.push_back(int'(bdi_data[6:0]));
      wr_log.push_back(int'(bdi_data[6:0]));
    end
    if (bdo_rden && bdo_q.size() > 0) void'(bdo_q.pop_front());
    if (tx_go && bdi_q.size() > 0 && $urandom_range(1, 0) == 1) bdo_q.push_back(bdi_q.pop_front());
    bdo_empty = bdo_q.size() == 0;
    bdo_data = bdo_empty ? 7'd0 : 7'(bdo_q[0]);
    bdi_full = bdi_q.size() >= MAXI || (full_rnd && $urandom_range(2, 0) == 0);
    host_commit = cm;
    host_ack = ak;
  endtask

  task automatic do_reset();
    bdi_q.delete(); bdo_q.delete(); wr_log.delete();
    rst = 1'b1; ctrl_ena = 1'b0; tx_go = 1'b0; full_rnd = 1'b0; last_wr = -10;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic commits(input int n);
    repeat (n) begin cyc(1'b1); cyc(); end
  endtask

  task automatic wait_st(input string tag, input int s, input int lim);
    for (int i = 0; i < lim && int'(st_state) != s; i++) cyc();
    chk(tag, st_state, s);
  endtask

  function automatic int logv(input int i);
    return i < wr_log.size() ? wr_log[i] : -1;
  endfunction

  initial begin
    int n_wr;
    int exp2[4] = '{126, 127, 0, 1};
    do_reset();
    chk("rst_state", st_state, 0);
    chk("rst_wren", bdi_wren, 0);
    chk("rst_infl", st_inflight, 0);
    chk("rst_done", st_done_cnt, 0);
    chk("rst_irq", irq, 0);
    ctrl_start_mf = 7'd5; ctrl_crc_e = 2'b10; ctrl_ena = 1'b1;
    cyc(); commits(3); run(8);
    chk("s1_writes", wr_log.size(), 3);
    chk("s1_infl", st_inflight, 3);
    for (int i = 0; i < 3; i++) chk("s1_mf", logv(i), 5 + i);
    tx_go = 1'b1; run(30);
    chk("s1_done", st_done_cnt, 3);
    repeat (3) begin cyc(1'b0, 1'b1); cyc(); end
    run(2);
    chk("s1_ack", st_done_cnt, 0);

    do_reset();
    ctrl_start_mf = 7'd126; ctrl_irq_thr = 4'd0; ctrl_ena = 1'b1;
    cyc(); commits(4); run(6);
    ctrl_ena = 1'b0; tx_go = 1'b1;
    wait_st("s2_idle", 0, 80);
    for (int i = 0; i < 4; i++) chk("s2_wrap_mf", logv(i), exp2[i]);
    chk("s2_done", st_done_cnt, 4);
    chk("s2_irq", irq, 1);
    repeat (4) begin cyc(1'b0, 1'b1); cyc(); end
    run(2);
    chk("s2_done0", st_done_cnt, 0);
    chk("s2_irq0", irq, 0);

    do_reset();
    ctrl_start_mf = 7'($urandom); ctrl_ena = 1'b1;
    cyc(); commits(6); run(6);
    chk("s3_writes", wr_log.size(), 4);
    chk("s3_infl", st_inflight, 4);
    bdo_q.push_back(bdi_q.pop_front());
    run(8);
    chk("s3_fifth", wr_log.size(), 5);

    do_reset();
    ctrl_start_mf = 7'd10; ctrl_ena = 1'b1;
    cyc(); commits(2); run(4);
    chk("s4_writes", wr_log.size(), 2);
    bdi_q.delete(); bdo_q.push_back(11); bdo_q.push_back(10);
    run(8);
    chk("s4_seq_err", st_seq_err, 1);
    chk("s4_state", st_state, 3);
    chk("s4_irq", irq, 1);
    chk("s4_popped", bdo_q.size(), 0);
    ctrl_ena = 1'b0; run(2);
    chk("s4_idle", st_state, 0);

    do_reset();
    ctrl_start_mf = 7'($urandom); ctrl_ena = 1'b1;
    cyc(); tx_go = 1'b1; commits(2); run(30);
    chk("s5_starve", st_starve, 1);
    chk("s5_run", st_state, 1);
    tx_go = 1'b0; commits(2); run(2);
    n_wr = wr_log.size();
    ctrl_ena = 1'b0; cyc();
    chk("s5_drain", st_state, 2);
    tx_go = 1'b1;
    wait_st("s5_idle", 0, 80);
    chk("s5_nowr", wr_log.size(), n_wr);

    do_reset();
    ctrl_irq_thr = 4'd3; ctrl_start_mf = 7'd20; ctrl_ena = 1'b1;
    cyc(); commits(3); run(4);
    for (int k = 0; k < 2; k++) begin bdo_q.push_back(bdi_q.pop_front()); run(4); end
`ifdef E1_TX_BD_SEQ_IRQ_COAL_EN
    chk("s6_irq2", irq, 0);
`else
    chk("s6_irq2", irq, 1);
`endif
    bdo_q.push_back(bdi_q.pop_front()); run(4);
    chk("s6_irq3", irq, 1);

    do_reset();
    ctrl_ena = 1'b1;
    cyc(); repeat (130) cyc(1'b1); cyc(); run(3);
    chk("s7_ovf", st_commit_ovf, 1);
    chk("s7_irq", irq, 1);

    repeat (8) begin
      do_reset();
      ctrl_start_mf = 7'($urandom); ctrl_crc_e = 2'($urandom); ctrl_irq_thr = 4'($urandom);
      full_rnd = 1'b1; tx_go = 1'b1; ctrl_ena = 1'b1;
      for (int c = 0; c < 400; c++) begin
        if (m_st == 3 && bdi_q.size() == 0 && bdo_q.size() == 0) break;
        if ($urandom_range(99, 0) < 3) begin
          ctrl_ena = !ctrl_ena;
          ctrl_start_mf = 7'($urandom);
        end
        if ($urandom_range(199, 0) == 0 && bdi_q.size() >= 2) begin
          int t = bdi_q[0];
          bdi_q[0] = bdi_q[1];
          bdi_q[1] = t;
        end
        cyc(1'($urandom_range(9, 0) < 4), 1'($urandom_range(9, 0) < 3));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
